uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_tx_fifo.sv | 38 +++
 rtl/uart_tx_param.sv | 108 ++++++++++
 tb/tb_uart_tx_param.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants and transmitter FSM encoding shared by the UART TX files.
package uart_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two FIFO; pointers wrap naturally at DEPTH.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter fed by a small FIFO.
// txd is registered; each bit is timed by a down-counter reloaded with CLK_DIV-1.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          s_valid,
   input  logic [DATA_W-1:0]             s_data,
   output logic                          s_ready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_W);
   localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam bit HAS_PAR = PARITY != PAR_NONE;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [BW-1:0] bit_cnt, bit_n;
   logic [DATA_W-1:0] shreg, shreg_n, rd_data;
   logic par_bit, par_n, txd_n, pop, push, full, empty, tick;
   assign push = s_valid && s_ready;
   assign s_ready = !reset && !full;
   assign busy = !reset && (state != ST_IDLE || !empty);
   assign tick = cnt == '0;
   uart_tx_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) fifo (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .wr_data(s_data),
      .rd_data(rd_data), .full(full), .empty(empty), .level(level)
   );
   // txd_n is the line value for the cycle after this edge, so txd changes exactly with state
   always_comb begin
      state_n = state;
      txd_n = txd;
      shreg_n = shreg;
      par_n = par_bit;
      bit_n = bit_cnt;
      pop = 1'b0;
      cnt_n = tick ? cnt : cnt - 1'b1;
      case (state)
         ST_IDLE: if (!empty) begin
            pop = 1'b1;
            state_n = ST_START;
         end
         ST_START: if (tick) begin
            state_n = ST_DATA;
            txd_n = shreg[0];
         end
         ST_DATA: if (tick) begin
            if (bit_cnt == LAST_DATA) begin
               state_n = HAS_PAR ? ST_PAR : ST_STOP;
               txd_n = HAS_PAR ? par_bit : 1'b1;
               bit_n = '0;
            end else begin
               bit_n = bit_cnt + 1'b1;
               shreg_n = shreg >> 1;
               txd_n = shreg[1];
            end
         end
         ST_PAR: if (tick) begin
            state_n = ST_STOP;
            txd_n = 1'b1;
         end
         ST_STOP: if (tick) begin
            if (bit_cnt == LAST_STOP) begin
               bit_n = '0;
               pop = !empty;
               state_n = empty ? ST_IDLE : ST_START;
            end else begin
               bit_n = bit_cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (pop) begin
         txd_n = 1'b0;
         shreg_n = rd_data;
         par_n = (^rd_data) ^ (PARITY == PAR_ODD);
      end
      if (state_n != ST_IDLE && (state_n != state || tick)) cnt_n = CNT_LOAD;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt <= '0;
         bit_cnt <= '0;
         shreg <= '0;
         par_bit <= 1'b0;
         txd <= 1'b1;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_cnt <= bit_n;
         shreg <= shreg_n;
         par_bit <= par_n;
         txd <= txd_n;
      end
   end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations checked cycle by cycle against a queue-based line model.
module tb_uart_tx_param;
   localparam int DIV = 4;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic reset;
   logic [3:0] s_valid, s_ready, txd, busy;
   logic [7:0] s_data;
   logic [2:0] level [4];
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   // channel 0: even/1 stop, 1: odd/1 stop, 2: no parity/1 stop, 3: even/2 stops
   for (genvar g = 0; g < 4; g++) begin : ch
      localparam int PAR = g == 1 ? 2 : g == 2 ? 0 : 1;
      localparam int STOPS = g == 3 ? 2 : 1;
      uart_tx_param #(.DATA_W(8), .CLK_DIV(DIV), .PARITY(PAR), .STOP_BITS(STOPS), .FIFO_DEPTH(DEPTH)) dut (
         .clk(clk), .reset(reset), .s_valid(s_valid[g]), .s_data(s_data),
         .s_ready(s_ready[g]), .txd(txd[g]), .busy(busy[g]), .level(level[g])
      );
      logic [7:0] fq [$];
      bit lq [$];
      bit in_frame, exp_txd, v;
      logic [7:0] w;
      int n0;
      always @(posedge clk) begin
         if (reset) begin
            fq.delete();
            lq.delete();
            in_frame = 0;
            exp_txd = 1;
         end else begin
            n0 = fq.size();
            if (lq.size() == 0 && n0 != 0) begin
               w = fq.pop_front();
               for (int b = 0; b < 9 + (PAR != 0) + STOPS; b++) begin
                  v = b == 0 ? 1'b0 : b <= 8 ? w[b-1] : (PAR != 0 && b == 9) ? ((^w) ^ (PAR == 2)) : 1'b1;
                  repeat (DIV) lq.push_back(v);
               end
            end
            in_frame = lq.size() != 0;
            exp_txd = in_frame ? lq.pop_front() : 1'b1;
            if (s_valid[g] && n0 < DEPTH) fq.push_back(s_data);
         end
         #1;
         check($sformatf("txd%0d", g), int'(txd[g]), int'(exp_txd));
         check($sformatf("level%0d", g), int'(level[g]), fq.size());
         check($sformatf("busy%0d", g), int'(busy[g]), int'(!reset && (in_frame || fq.size() != 0)));
         check($sformatf("ready%0d", g), int'(s_ready[g]), int'(!reset && fq.size() < DEPTH));
      end
   end
   task automatic push_all(input logic [7:0] d);
      s_valid = 4'hF;
      s_data = d;
      @(negedge clk);
      s_valid = '0;
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         if (busy == 4'h0) break;
      end
      check("idle_wait", int'(busy), 0);
   endtask
   initial begin
      logic [10:0] cd_bits;
      int cnt [4];
      int exp_len [4];
      int thr;
      cd_bits = {1'b1, 1'b1, 8'hCD, 1'b0};
      exp_len = '{44, 44, 40, 48};
      reset = 1'b1;
      s_valid = '0;
      s_data = '0;
      repeat (3) @(negedge clk);
      check("rst_txd", int'(txd), 4'hF);
      check("rst_ready", int'(s_ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_level", int'(level[0]), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", int'(s_ready), 4'hF);
      @(negedge clk);
      push_all(8'hCD);
      repeat (3) @(posedge clk);
      for (int k = 0; k < 11; k++) begin
         #1;
         check($sformatf("cd_bit%0d", k), int'(txd[0]), int'(cd_bits[k]));
         if (k == 9) check("odd_parity", int'(txd[1]), 0);
         repeat (4) @(posedge clk);
      end
      wait_idle();
      @(negedge clk);
      push_all(8'h00);
      cnt = '{0, 0, 0, 0};
      repeat (70) begin
         @(posedge clk);
         #1;
         for (int g = 0; g < 4; g++) if (busy[g] && level[g] == 0) cnt[g]++;
      end
      for (int g = 0; g < 4; g++) check($sformatf("frame_len%0d", g), cnt[g], exp_len[g]);
      @(negedge clk);
      s_valid = 4'hF;
      for (int i = 0; i < 6; i++) begin
         s_data = 8'($urandom);
         @(negedge clk);
         if (i == 4) begin
            check("burst_level", int'(level[0]), 4);
            check("burst_ready", int'(s_ready[0]), 0);
         end
      end
      s_valid = '0;
      wait_idle();
      @(negedge clk);
      push_all(8'h5A);
      push_all(8'h3C);
      push_all(8'hA5);
      repeat (15) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_txd", int'(txd), 4'hF);
      check("abort_level", int'(level[0]), 0);
      check("abort_busy", int'(busy), 0);
      repeat (60) @(negedge clk);
      check("abort_quiet_txd", int'(txd), 4'hF);
      check("abort_quiet_busy", int'(busy), 0);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         thr = i < 1500 ? 3 : 60;
         for (int g = 0; g < 4; g++) s_valid[g] = $urandom_range(0, thr) == 0;
         s_data = 8'($urandom);
         reset = $urandom_range(0, 399) == 0;
      end
      @(negedge clk);
      s_valid = '0;
      reset = 1'b0;
      wait_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
